mips_cpu_muldiv: RTL and testbench
==================================

// Module: mips_cpu_muldiv
// PURPOSE
//   Multi-cycle integer multiply/divide unit for the MIPS CPU core; replaces the combinational
//   '*', '/', '%' operators feeding HI/LO. Operands come from register-file read ports A (Rs)
//   and B (Rt); results are written into the CPU's HI/LO registers. The CPU stalls on busy.
//   Radix-2 shift-add multiplier, radix-2 restoring divider, sign-magnitude handling for signed ops.
// PARAMETERS
//   WIDTH  32  operand width; hi/lo are WIDTH each, iteration count = WIDTH
// PORTS
//   clk          in   1      clock
//   reset        in   1      synchronous, active-high reset
//   start        in   1      request; sampled only in IDLE
//   op           in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
//   a            in   WIDTH  Rs: multiplicand / dividend; sampled with start
//   b            in   WIDTH  Rt: multiplier / divisor; sampled with start
//   busy         out  1      operation in progress; CPU holds clk_enable low
//   done         out  1      one-cycle pulse; hi/lo valid from this cycle
//   hi           out  WIDTH  MULT: product[63:32]; DIV: remainder
//   lo           out  WIDTH  MULT: product[31:0];  DIV: quotient
//   div_zero     out  1      set with done if a DIV/DIVU had b==0; cleared on next accepted start
// BEHAVIOUR
//   - Reset: state=IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0; reset mid-operation aborts it.
//   - States: IDLE -> CALC -> FIX -> IDLE.
//   - IDLE: start=1 at edge N: latch op, |a|, |b| (abs only for signed ops), result signs, count=0;
//     -> CALC. busy=1 from after edge N until done.
//   - CALC: one bit per edge, WIDTH edges (N+1..N+WIDTH), then -> FIX.
//     Multiply: acc(2*WIDTH) += mcand if mplier[0]; mcand<<=1; mplier>>=1.
//     Divide: rem = {rem,quo[MSB]}; if rem>=divisor subtract and shift in 1, else shift in 0.
//   - FIX (edge N+WIDTH+1): negate product if signs differ (MULT); negate quotient if signs differ,
//     give remainder the dividend's sign (DIV); write hi/lo; done=1, busy=0; -> IDLE.
//   - Latency: done visible after edge N+WIDTH+1 (N+33 at WIDTH=32).
//   - done is high exactly one cycle. start in that same cycle is accepted (back-to-back ops).
//   - start while busy: ignored, no queueing; op/a/b changes while busy have no effect.
//   - hi/lo hold their values until the FIX edge of the next accepted operation.
//   - Divide by zero (b==0): no exception; full latency; hi=a (unmodified), lo={WIDTH{1}}, div_zero=1.
//   - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps, no flag).
//   - Signed DIV truncates toward zero; remainder sign = dividend sign (e.g. -7/2: lo=-3, hi=-1).
//   - Arithmetic unsigned internally; abs(0x80000000)=0x80000000 treated as unsigned magnitude.
// CONFIGURATION
//   MULDIV_EARLY_TERM_EN defined: multiply leaves CALC on the edge where mplier (after its shift)
//     is 0; if |b| highest set bit is k, done after edge N+k+2; |b|==0 gives done after N+2.
//     Divide latency unchanged.
//   Not defined: every operation takes the fixed N+WIDTH+1 latency.
// TESTING
//   MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001, done after edge N+33.
//   MULT a=-3 b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB; with MULDIV_EARLY_TERM_EN done after N+4.
//   DIV a=-7 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; DIVU a=100 b=7 -> lo=14 hi=2.
//   DIVU a=0x1234 b=0 -> hi=0x1234 lo=0xFFFFFFFF div_zero=1; next accepted start clears div_zero.
//   start pulsed every cycle during busy -> only first op runs; start in done cycle -> 2nd op accepted.
//   reset at edge N+10 of a DIVU -> busy=0, done=0, hi=lo=0; no done pulse follows.

Source files
------------

// File: rtl/mips_cpu_muldiv.sv
// mips_cpu_muldiv: multi-cycle MULT/MULTU/DIV/DIVU unit for HI/LO; MULDIV_EARLY_TERM_EN enables early multiply exit
module mips_cpu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_n;
  logic [CW-1:0] count;
  logic is_div, neg_q, neg_r, b_zero, calc_end, ge;
  logic sign_a, sign_b;
  logic [WIDTH-1:0] abs_a, abs_b, mplier, rem, quo, divisor, quot, remd;
  logic [2*WIDTH-1:0] acc, mcand, prod;
  logic [WIDTH:0] trial;
  assign sign_a = ~op[0] & a[WIDTH-1];
  assign sign_b = ~op[0] & b[WIDTH-1];
  assign abs_a = sign_a ? -a : a;
  assign abs_b = sign_b ? -b : b;
  assign trial = {rem, quo[WIDTH-1]};
  assign ge = trial >= {1'b0, divisor};
  assign prod = neg_q ? -acc : acc;
  assign quot = neg_q ? -quo : quo;
  assign remd = neg_r ? -rem : rem;
  assign busy = state != IDLE;
`ifdef MULDIV_EARLY_TERM_EN
  assign calc_end = count == CW'(WIDTH - 1) || (!is_div && mplier[WIDTH-1:1] == '0);
`else
  assign calc_end = count == CW'(WIDTH - 1);
`endif
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (start ? CALC : IDLE) :
              state == CALC ? (calc_end ? FIX : CALC) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      done <= 1'b0;
      div_zero <= 1'b0;
      hi <= '0;
      lo <= '0;
      count <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      b_zero <= 1'b0;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      rem <= '0;
      quo <= '0;
      divisor <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        div_zero <= 1'b0;
        is_div <= op[1];
        neg_q <= sign_a ^ sign_b;
        neg_r <= sign_a;
        b_zero <= b == '0;
        count <= '0;
        acc <= '0;
        mcand <= {{WIDTH{1'b0}}, abs_a};
        mplier <= abs_b;
        rem <= '0;
        quo <= abs_a;
        divisor <= abs_b;
      end else if (state == CALC) begin
        count <= count + CW'(1);
        if (is_div) begin
          rem <= ge ? trial[WIDTH-1:0] - divisor : trial[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], ge};
        end else begin
          if (mplier[0]) acc <= acc + mcand;
          mcand <= mcand << 1;
          mplier <= mplier >> 1;
        end
      end else if (state == FIX) begin
        done <= 1'b1;
        hi <= is_div ? remd : prod[2*WIDTH-1:WIDTH];
        lo <= is_div ? (b_zero ? '1 : quot) : prod[WIDTH-1:0];
        div_zero <= is_div & b_zero;
      end
    end
  end
endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// tb_mips_cpu_muldiv: randomized and directed self-check of mips_cpu_muldiv against an arithmetic model
module tb_mips_cpu_muldiv;
  logic clk = 1'b0;
  logic reset, start, busy, done, div_zero;
  logic [1:0] op;
  logic [31:0] a, b, hi, lo;
  int checks = 0, passed = 0;
  mips_cpu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (o[1] && y == 0) return {1'b1, x, 32'hffffffff};
    case (o)
      2'd0: p = 64'(sx * sy);
      2'd1: p = {32'd0, x} * {32'd0, y};
      2'd2: p = {32'(sx % sy), 32'(sx / sy)};
      default: p = {x % y, x / y};
    endcase
    return {1'b0, p};
  endfunction
  function automatic int lat(input logic [1:0] o, input logic [31:0] y);
    int k;
    logic [31:0] m;
    k = 0;
    m = (!o[0] && y[31]) ? -y : y;
`ifdef MULDIV_EARLY_TERM_EN
    if (!o[1]) begin
      for (int i = 0; i < 32; i++) if (m[i]) k = i;
      return m == 0 ? 2 : k + 2;
    end
`endif
    return 33 + k * int'(m == 0 && k != 0);
  endfunction
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
    logic [63:0] prev;
    prev = {hi, lo};
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    chk({tag, "_dzclr"}, 64'(div_zero), 64'd0);
    chk({tag, "_hold"}, {hi, lo}, prev);
  endtask
  task automatic wait_done(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
    int n;
    logic [64:0] e;
    n = 0;
    e = model(o, x, y);
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 40);
    chk({tag, "_lat"}, 64'(n), 64'(lat(o, y)));
    chk({tag, "_hi"}, 64'(hi), 64'(e[63:32]));
    chk({tag, "_lo"}, 64'(lo), 64'(e[31:0]));
    chk({tag, "_dz"}, 64'(div_zero), 64'(e[64]));
  endtask
  task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
    logic [63:0] res;
    issue(o, x, y, tag);
    wait_done(o, x, y, tag);
    res = {hi, lo};
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, 64'({done, busy}), 64'd0);
    chk({tag, "_keep"}, {hi, lo}, res);
  endtask
  initial begin
    logic [1:0] o;
    logic [31:0] x, y;
    bit seen;
    reset = 1'b1;
    start = 1'b0;
    op = 2'd0;
    a = 32'd0;
    b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz", 64'(div_zero), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    run(2'd1, 32'hffffffff, 32'hffffffff, "multu_max");
    run(2'd0, -32'sd3, 32'd7, "mult_neg");
    run(2'd2, -32'sd7, 32'd2, "div_neg");
    run(2'd3, 32'd100, 32'd7, "divu");
    run(2'd3, 32'h1234, 32'd0, "divu_zero");
    run(2'd2, 32'h80000000, 32'hffffffff, "div_ovf");
    run(2'd2, 32'h80000005, 32'd0, "div_zero_neg");
    run(2'd0, 32'h12345678, 32'd0, "mult_zero");
    run(2'd0, 32'h80000000, 32'h80000000, "mult_min");
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom_range(0, 7) == 0 ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 3))
        0: y = 32'd0;
        1: y = $urandom_range(0, 15);
        2: y = -$urandom_range(1, 15);
        default: y = $urandom;
      endcase
      run(o, x, y, $sformatf("rnd%0d", i));
    end
    issue(2'd3, 32'd1000, 32'd9, "b2b_first");
    start = 1'b1;
    op = 2'd0;
    a = 32'hfffffff0;
    b = 32'd5;
    wait_done(2'd3, 32'd1000, 32'd9, "b2b_first");
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_accept", 64'({busy, done}), 64'd2);
    wait_done(2'd0, 32'hfffffff0, 32'd5, "b2b_second");
    @(posedge clk);
    #1;
    issue(2'd3, 32'hdeadbeef, 32'd3, "abort");
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_state", 64'({busy, done, div_zero}), 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      seen |= done | busy;
    end
    chk("abort_quiet", 64'(seen), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
